// File: rtl/fdiv_p2_pkg.sv
// Shared definitions for the FP divide pipeline stages: widths, bias,
// the iterative divider state encoding and the exponent type.
package fdiv_p2_pkg;

  localparam int FP_MANT_W = 24;
  localparam int FP_QUOT_W = 26;
  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 10;
  localparam int FP_CNT_W  = $clog2(FP_QUOT_W);

  // Exponent as carried between the fmul/fdiv stages: 10-bit two's complement.
  typedef logic signed [FP_EXP_W-1:0] exp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fdiv_state_e;

endpackage

// File: rtl/fdiv_p2_if.sv
// Operand and result handshake bundle between fdiv stage 1, this stage and stage 3.
interface fdiv_p2_if
  import fdiv_p2_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int QUOT_W = FP_QUOT_W
);

  // Operand side (from stage 1)
  logic              in_valid;
  logic              in_ready;
  logic              sign_in;
  exp_t              exp_diff_in;
  logic [MANT_W-1:0] mant_a_in;
  logic [MANT_W-1:0] mant_b_in;

  // Result side (to stage 3)
  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  exp_t              exp_out;
  logic [QUOT_W-1:0] quot_out;
  logic              sticky_out;
  logic              dbz_out;

  // Divider end of the bundle
  modport slave (
    input  in_valid, sign_in, exp_diff_in, mant_a_in, mant_b_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, quot_out, sticky_out, dbz_out
  );

  // Producer/consumer end of the bundle
  modport master (
    output in_valid, sign_in, exp_diff_in, mant_a_in, mant_b_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, quot_out, sticky_out, dbz_out
  );

endinterface

// File: rtl/fdiv_p2_step.sv
// One radix-2 restoring division iteration: compare, conditionally subtract,
// then shift the partial remainder left for the next quotient bit.
module fdiv_step #(
  parameter int MANT_W = 24
) (
  input  logic [MANT_W:0]   rem_i,
  input  logic [MANT_W-1:0] div_i,
  output logic [MANT_W:0]   next_rem_o,
  output logic              q_bit_o
);

  logic [MANT_W:0] div_ext;
  logic [MANT_W:0] diff;
  logic [MANT_W:0] sel;

  // Restoring step: keep the difference only when it does not go negative.
  always_comb begin
    div_ext    = {1'b0, div_i};
    diff       = rem_i - div_ext;
    q_bit_o    = (rem_i >= div_ext);
    sel        = q_bit_o ? diff : rem_i;
    next_rem_o = sel << 1;
  end

endmodule

// File: rtl/fdiv_p2.sv
// fdiv stage 2: iterative restoring mantissa divider producing one quotient
// bit per cycle, plus re-biased exponent, sticky and divide-by-zero flags.
module fdiv_p2
  import fdiv_p2_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int QUOT_W = FP_QUOT_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  fdiv_p2_if.slave  bus
);

  localparam int CNT_W = $clog2(QUOT_W);

  fdiv_state_e       state_q, state_d;
  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Holds the QUOT_W-1 bits already produced; the last bit joins on the final step.
  logic [QUOT_W-2:0] acc_q, acc_d;
  logic              sign_q, sign_d;
  exp_t              exp_q, exp_d;
  logic              dbz_q, dbz_d;

  logic              sign_out_q, sign_out_d;
  exp_t              exp_out_q, exp_out_d;
  logic [QUOT_W-1:0] quot_out_q, quot_out_d;
  logic              sticky_out_q, sticky_out_d;
  logic              dbz_out_q, dbz_out_d;

  logic              in_ready, out_valid;
  logic [MANT_W:0]   step_rem;
  logic              step_q;

  fdiv_step #(.MANT_W(MANT_W)) u_step (
    .rem_i      (rem_q),
    .div_i      (div_q),
    .next_rem_o (step_rem),
    .q_bit_o    (step_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, handshake outputs and datapath next values.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    dbz_d        = dbz_q;
    sign_out_d   = sign_out_q;
    exp_out_d    = exp_out_q;
    quot_out_d   = quot_out_q;
    sticky_out_d = sticky_out_q;
    dbz_out_d    = dbz_out_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;

    if (flush) begin
      // Abort wins over everything but reset; no accept in the same cycle.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            rem_d   = {1'b0, bus.mant_a_in};
            div_d   = bus.mant_b_in;
            cnt_d   = CNT_W'(QUOT_W - 1);
            acc_d   = '0;
            sign_d  = bus.sign_in;
            exp_d   = exp_t'(bus.exp_diff_in + exp_t'(BIAS));
            dbz_d   = (bus.mant_b_in == '0);
            state_d = BUSY;
          end
        end
        BUSY: begin
          rem_d = step_rem;
          acc_d = {acc_q[QUOT_W-3:0], step_q};
          if (cnt_q == '0) begin
            // Result registers change only here, on entry to DONE.
            quot_out_d   = dbz_q ? '1 : {acc_q, step_q};
            sticky_out_d = dbz_q | (step_rem != '0);
            sign_out_d   = sign_q;
            exp_out_d    = exp_q;
            dbz_out_d    = dbz_q;
            state_d      = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          out_valid = 1'b1;
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and result registers; all cleared by reset so no stale result leaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q        <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      dbz_q        <= 1'b0;
      sign_out_q   <= 1'b0;
      exp_out_q    <= '0;
      quot_out_q   <= '0;
      sticky_out_q <= 1'b0;
      dbz_out_q    <= 1'b0;
    end else begin
      rem_q        <= rem_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      dbz_q        <= dbz_d;
      sign_out_q   <= sign_out_d;
      exp_out_q    <= exp_out_d;
      quot_out_q   <= quot_out_d;
      sticky_out_q <= sticky_out_d;
      dbz_out_q    <= dbz_out_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.sign_out   = sign_out_q;
  assign bus.exp_out    = exp_out_q;
  assign bus.quot_out   = quot_out_q;
  assign bus.sticky_out = sticky_out_q;
  assign bus.dbz_out    = dbz_out_q;

endmodule

// File: tb/tb_fdiv_p2.sv
// Directed bench for fdiv_p2: hand-computed quotients, latency, stall,
// divide-by-zero, flush, mid-operation reset and back-to-back spacing.
module tb_fdiv_p2;
  import fdiv_p2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  fdiv_p2_if bus ();

  fdiv_p2 dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive_ops(input logic [23:0] a, input logic [23:0] b,
                           input logic [9:0] e, input logic s);
    bus.mant_a_in   = a;
    bus.mant_b_in   = b;
    bus.exp_diff_in = e;
    bus.sign_in     = s;
  endtask

  // Wait (bounded) for in_ready, then present one operand set for one edge.
  task automatic start_op(input logic [23:0] a, input logic [23:0] b,
                          input logic [9:0] e, input logic s);
    int n = 0;
    while (!bus.in_ready && n < 60) begin tick(); n++; end
    check("ready_before_op", 32'(bus.in_ready), 32'd1);
    drive_ops(a, b, e, s);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid; 60 means it never came.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin tick(); lat++; end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [25:0] q, input logic st,
                              input logic [9:0] e, input logic s, input logic dz);
    check({tag, "_valid"},  32'(bus.out_valid),  32'd1);
    check({tag, "_quot"},   32'(bus.quot_out),   32'(q));
    check({tag, "_sticky"}, 32'(bus.sticky_out), 32'(st));
    check({tag, "_exp"},    {22'b0, bus.exp_out}, {22'b0, e});
    check({tag, "_sign"},   32'(bus.sign_out),   32'(s));
    check({tag, "_dbz"},    32'(bus.dbz_out),    32'(dz));
  endtask

  initial begin
    int lat;
    int hi;
    int n;
    int acc0;
    int acc1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops(24'h0, 24'h0, 10'h0, 1'b0);

    // Reset state while rst is held.
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot",      32'(bus.quot_out),  32'd0);
    check("rst_exp",       {22'b0, bus.exp_out}, 32'd0);
    check("rst_sticky",    32'(bus.sticky_out), 32'd0);
    check("rst_dbz",       32'(bus.dbz_out),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1.5 / 1.0
    start_op(24'hC00000, 24'h800000, 10'h000, 1'b0);
    wait_out(lat);
    check("t1_latency", 32'(lat), 32'd26);
    check_result("t1", 26'h3000000, 1'b0, 10'h07F, 1'b0, 1'b0);
    finish_op();

    // 1.0 / 1.5, negative exponent difference
    start_op(24'h800000, 24'hC00000, 10'h3FD, 1'b1);
    wait_out(lat);
    check("t2_latency", 32'(lat), 32'd26);
    check_result("t2", 26'h1555555, 1'b1, 10'h07C, 1'b1, 1'b0);
    finish_op();

    // max / max, then stall with a competing in_valid
    start_op(24'hFFFFFF, 24'hFFFFFF, 10'h001, 1'b0);
    wait_out(lat);
    check("t3_latency", 32'(lat), 32'd26);
    check_result("t3", 26'h2000000, 1'b0, 10'h080, 1'b0, 1'b0);
    drive_ops(24'h800000, 24'hC00000, 10'h3FD, 1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_ready", 32'(bus.in_ready),  32'd0);
      check("t3_hold_quot",  32'(bus.quot_out),  32'h2000000);
      check("t3_hold_exp",   {22'b0, bus.exp_out}, 32'h080);
    end
    bus.in_valid = 1'b0;
    finish_op();
    check("t3_idle_ready", 32'(bus.in_ready),  32'd1);
    check("t3_idle_valid", 32'(bus.out_valid), 32'd0);

    // divide by zero, then a normal op clears dbz
    start_op(24'h9A0000, 24'h000000, 10'h000, 1'b0);
    wait_out(lat);
    check("t4_latency", 32'(lat), 32'd26);
    check_result("t4", 26'h3FFFFFF, 1'b1, 10'h07F, 1'b0, 1'b1);
    finish_op();
    start_op(24'hC00000, 24'h800000, 10'h000, 1'b0);
    wait_out(lat);
    check_result("t4b", 26'h3000000, 1'b0, 10'h07F, 1'b0, 1'b0);
    finish_op();

    // flush at BUSY cycle 12
    start_op(24'h9A0000, 24'h800000, 10'h000, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.out_valid) hi++; end
    check("t5_flush_no_valid", 32'(hi), 32'd0);
    check("t5_flush_ready",    32'(bus.in_ready), 32'd1);
    start_op(24'h800000, 24'hC00000, 10'h000, 1'b0);
    wait_out(lat);
    check("t5_latency", 32'(lat), 32'd26);
    check_result("t5", 26'h1555555, 1'b1, 10'h07F, 1'b0, 1'b0);
    finish_op();

    // reset mid-BUSY: previous result must vanish
    start_op(24'hFFFFFF, 24'h800000, 10'h010, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check("t6_in_ready",  32'(bus.in_ready),  32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_quot",      32'(bus.quot_out),  32'd0);
    check("t6_sticky",    32'(bus.sticky_out), 32'd0);
    check("t6_exp",       {22'b0, bus.exp_out}, 32'd0);
    check("t6_sign",      32'(bus.sign_out),  32'd0);
    tick();
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.out_valid) hi++; end
    check("t6_no_partial", 32'(hi), 32'd0);

    // back-to-back with out_ready held high
    bus.out_ready = 1'b1;
    drive_ops(24'hC00000, 24'h800000, 10'h005, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    acc0 = cyc;
    drive_ops(24'h800000, 24'hC00000, 10'h1FF, 1'b1);
    wait_out(lat);
    check("t7a_latency", 32'(lat), 32'd26);
    check_result("t7a", 26'h3000000, 1'b0, 10'h084, 1'b0, 1'b0);
    n = 0;
    tick();
    while (!bus.in_ready && n < 60) begin tick(); n++; end
    tick();
    acc1 = cyc;
    bus.in_valid = 1'b0;
    check("t7_spacing", 32'(acc1 - acc0), 32'd28);
    wait_out(lat);
    check("t7b_latency", 32'(lat), 32'd26);
    check_result("t7b", 26'h1555555, 1'b1, 10'h27E, 1'b1, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    check("t7_end_ready", 32'(bus.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
